aibnd_avmm2_xfer: RTL and testbench

Digital AVMM channel-2 framing stage that sits directly upstream of the AVMM2 IO buffer block. It serializes parallel AVMM words into framed 2-lane DDR nibbles driven on `avmm2_idat0/avmm2_idat1`, and deserializes the 2-lane receive stream from `avmm2_odat0/avmm2_odat1` back into parallel words. Transmit uses a valid/ready handshake; receive is a one-cycle strobe with no backpressure.

---
 rtl/aibnd_avmm2_pkg.sv | 15 +
 rtl/aibnd_avmm2_rxdeser.sv | 77 +++++++
 rtl/aibnd_avmm2_xfer.sv | 110 +++++++++++
 tb/tb_aibnd_avmm2_xfer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aibnd_avmm2_pkg.sv
// Shared types and constants for the AVMM channel-2 framing stage.
package aibnd_avmm2_pkg;

    typedef enum logic [1:0] {TIDLE, THDR, TDATA} tx_state_e;
    typedef enum logic       {RIDLE, RDATA}       rx_state_e;

    localparam logic [3:0] AVMM2_HDR_NIB  = 4'hF;
    localparam logic [3:0] AVMM2_IDLE_NIB = 4'h0;

    // Nibble onto the pad pair {idat1, idat0}: lane0 carries b0/b2, lane1 carries b1/b3.
    function automatic logic [3:0] nib_to_pads(input logic [3:0] nib);
        return {nib[3], nib[1], nib[2], nib[0]};
    endfunction

endpackage

// File: rtl/aibnd_avmm2_rxdeser.sv
// RX side: registers the two lanes, waits for a header, collects DW/2 bit-pairs into a word.
module aibnd_avmm2_rxdeser
    import aibnd_avmm2_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic          lane0_i,
    input  logic          lane1_i,
    output logic [DW-1:0] rx_data_o,
    output logic          rx_valid_o
);

    localparam int unsigned NPAIR = DW / 2;
    localparam int unsigned PW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [PW-1:0] LAST_PAIR = PW'(NPAIR - 1);

    rx_state_e     state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [1:0]    lanes_q;
    logic [DW-1:0] shift_q, shift_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    // Lane values inside RDATA are always data; headers only count from RIDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            RIDLE: begin
                if (en_i && (lanes_q == 2'b11)) begin
                    state_d = RDATA;
                    cnt_d   = '0;
                end
            end
            RDATA: begin
                shift_d = {lanes_q, shift_q[DW-1:2]};
                if (cnt_q == LAST_PAIR) begin
                    data_d  = shift_d;
                    valid_d = 1'b1;
                    state_d = RIDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            default: state_d = RIDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RIDLE;
            cnt_q   <= '0;
            lanes_q <= 2'b00;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lanes_q <= {lane1_i, lane0_i};
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;

endmodule

// File: rtl/aibnd_avmm2_xfer.sv
// AVMM channel-2 framing: header + DW/4 DDR nibbles out on two lanes, deserializer in.
module aibnd_avmm2_xfer
    import aibnd_avmm2_pkg::*;
#(
    parameter int unsigned DW = 16
) (
    input  logic          avmm_clk,
    input  logic          avmm_sync_rstb,
    input  logic          avmm2_en,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic          tx_busy,
    output logic [1:0]    avmm2_idat0,
    output logic [1:0]    avmm2_idat1,
    input  logic          avmm2_odat0,
    input  logic          avmm2_odat1,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid
);

    localparam int unsigned NNIB = DW / 4;
    localparam int unsigned CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NNIB - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [3:0]    pads_q, pads_d;
    logic          accept;

    assign accept = tx_valid & ready_q;

    // Outputs are computed from the next state so every pad/handshake bit leaves a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            TIDLE: begin
                if (accept) begin
                    shift_d = tx_data;
                    state_d = THDR;
                end
            end
            THDR: begin
                state_d = TDATA;
                cnt_d   = '0;
            end
            TDATA: begin
                if (cnt_q == LAST_NIB) begin
                    if (accept) begin
                        shift_d = tx_data;
                        state_d = THDR;
                    end else begin
                        state_d = TIDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    shift_d = shift_q >> 4;
                end
            end
            default: state_d = TIDLE;
        endcase

        ready_d = avmm2_en & ((state_d == TIDLE) | ((state_d == TDATA) & (cnt_d == LAST_NIB)));
        busy_d  = (state_d != TIDLE);
        case (state_d)
            THDR:    pads_d = nib_to_pads(AVMM2_HDR_NIB);
            TDATA:   pads_d = nib_to_pads(shift_d[3:0]);
            default: pads_d = nib_to_pads(AVMM2_IDLE_NIB);
        endcase
    end

    always_ff @(posedge avmm_clk or negedge avmm_sync_rstb) begin
        if (!avmm_sync_rstb) begin
            state_q <= TIDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            pads_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            pads_q  <= pads_d;
        end
    end

    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign avmm2_idat0 = pads_q[1:0];
    assign avmm2_idat1 = pads_q[3:2];

    aibnd_avmm2_rxdeser #(.DW(DW)) u_rxdeser (
        .clk        (avmm_clk),
        .rst_n      (avmm_sync_rstb),
        .en_i       (avmm2_en),
        .lane0_i    (avmm2_odat0),
        .lane1_i    (avmm2_odat1),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid)
    );

endmodule

// File: tb/tb_aibnd_avmm2_xfer.sv
// Bench for aibnd_avmm2_xfer: vector table plus a cycle-by-cycle scoreboard of pads and RX words.
`timescale 1ns/1ps
module tb_aibnd_avmm2_xfer;

    localparam int unsigned DW = 16;

    logic          avmm_clk = 1'b0;
    logic          avmm_sync_rstb = 1'b1;
    logic          avmm2_en = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_busy;
    logic [1:0]    avmm2_idat0;
    logic [1:0]    avmm2_idat1;
    logic          avmm2_odat0 = 1'b0;
    logic          avmm2_odat1 = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;

    aibnd_avmm2_xfer #(.DW(DW)) dut (
        .avmm_clk       (avmm_clk),
        .avmm_sync_rstb (avmm_sync_rstb),
        .avmm2_en       (avmm2_en),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_busy        (tx_busy),
        .avmm2_idat0    (avmm2_idat0),
        .avmm2_idat1    (avmm2_idat1),
        .avmm2_odat0    (avmm2_odat0),
        .avmm2_odat1    (avmm2_odat1),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid)
    );

    always #5 avmm_clk = ~avmm_clk;

    typedef struct {
        logic [15:0] tx_word;
        logic [15:0] tx_pads;   // expected {idat1,idat0} per nibble, nibble 0 in [3:0]
        logic [7:0]  rx_l0;
        logic [7:0]  rx_l1;
        logic [15:0] rx_word;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          due;
    } rx_ent_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rx_pulses = 0;
    logic [15:0] cur_exp = '0;
    logic [3:0]  tx_q[$];
    rx_ent_t     rx_q[$];
    logic [15:0] exp_rx = '0;
    logic        en_prev = 1'b0;
    logic        rst_prev = 1'b0;
    logic [3:0]  exp_pads;
    logic        exp_busy;
    rx_ent_t     mon_e;
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge avmm_clk) cyc <= cyc + 1;

    // Scoreboard: every cycle compare pads/busy/ready and RX against the queued model.
    always @(negedge avmm_clk) begin
        if (!avmm_sync_rstb) begin
            tx_q.delete();
            rx_q.delete();
            exp_rx = '0;
            check("rst_pads", 32'({avmm2_idat1, avmm2_idat0}), 32'd0);
            check("rst_busy", 32'(tx_busy), 32'd0);
            check("rst_ready", 32'(tx_ready), 32'd0);
            check("rst_rx_valid", 32'(rx_valid), 32'd0);
            check("rst_rx_data", 32'(rx_data), 32'd0);
        end else begin
            if (tx_q.size() != 0) begin
                exp_pads = tx_q.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_pads = 4'b0000;
                exp_busy = 1'b0;
            end
            check("tx_pads", 32'({avmm2_idat1, avmm2_idat0}), 32'(exp_pads));
            check("tx_busy", 32'(tx_busy), 32'(exp_busy));
            check("tx_ready", 32'(tx_ready), 32'(en_prev && rst_prev && (tx_q.size() == 0)));

            while (rx_q.size() != 0 && rx_q[0].due < cyc) begin
                check("rx_pulse_missing", 32'(cyc), 32'(rx_q[0].due));
                void'(rx_q.pop_front());
            end
            if (rx_valid) begin
                rx_pulses++;
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_valid", 32'(rx_valid), 32'd0);
                end else begin
                    mon_e = rx_q.pop_front();
                    check("rx_valid_cycle", 32'(cyc), 32'(mon_e.due));
                    exp_rx = mon_e.data;
                end
            end
            check("rx_data", 32'(rx_data), 32'(exp_rx));

            if (tx_valid && tx_ready) begin
                tx_q.push_back(4'hF);
                for (int k = 0; k < 4; k++) tx_q.push_back(cur_exp[4*k +: 4]);
            end
        end
        en_prev  = avmm2_en;
        rst_prev = avmm_sync_rstb;
    end

    task automatic tick();
        @(posedge avmm_clk);
        #1;
    endtask

    task automatic send_tx(input logic [15:0] w, input logic [15:0] e);
        int n = 0;
        tx_data  = w;
        cur_exp  = e;
        tx_valid = 1'b1;
        @(negedge avmm_clk);
        while (!tx_ready) begin
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL tx_accept_timeout actual=no_ready expected=ready cyc=%0d", cyc);
                break;
            end
            @(negedge avmm_clk);
        end
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] l0, input logic [7:0] l1, input logic [15:0] w);
        rx_ent_t e;
        e.data = w;
        e.due  = cyc + DW/2 + 2;
        rx_q.push_back(e);
        avmm2_odat0 = 1'b1;
        avmm2_odat1 = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            avmm2_odat0 = l0[k];
            avmm2_odat1 = l1[k];
            tick();
        end
        avmm2_odat0 = 1'b0;
        avmm2_odat1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int c0;
        vecs[0] = '{16'hA5C3, 16'hC3A5, 8'h33, 8'h33, 16'h0F0F};
        vecs[1] = '{16'h1234, 16'h1452, 8'hFF, 8'h00, 16'h5555};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 8'h00, 8'hFF, 16'hAAAA};
        vecs[3] = '{16'h0000, 16'h0000, 8'h00, 8'h80, 16'h8000};
        vecs[4] = '{16'h8421, 16'h8241, 8'h01, 8'h00, 16'h0001};

        // Reset held with a word offered: nothing may move.
        #2;
        avmm_sync_rstb = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 16'hA5C3;
        repeat (3) tick();
        avmm_sync_rstb = 1'b1;
        tx_valid = 1'b0;
        tick();
        check("ready_after_reset", 32'(tx_ready), 32'd1);
        tick();

        foreach (vecs[i]) begin
            fork
                send_tx(vecs[i].tx_word, vecs[i].tx_pads);
                rx_frame(vecs[i].rx_l0, vecs[i].rx_l1, vecs[i].rx_word);
            join
            repeat (4) tick();
        end

        // Back-to-back TX: second accept lands on the last nibble of the first frame.
        send_tx(16'h1234, 16'h1452);
        c0 = cyc;
        send_tx(16'hFFFF, 16'hFFFF);
        check("tx_b2b_accept_gap", 32'(cyc - c0), 32'd5);
        repeat (8) tick();

        // Back-to-back RX with an all-ones payload first.
        p0 = rx_pulses;
        rx_frame(8'hFF, 8'hFF, 16'hFFFF);
        rx_frame(8'h01, 8'h00, 16'h0001);
        repeat (4) tick();
        check("rx_b2b_pulses", 32'(rx_pulses - p0), 32'd2);

        // Reset in the middle of both a TX and an RX frame.
        p0 = rx_pulses;
        send_tx(16'hA5C3, 16'hC3A5);
        avmm2_odat0 = 1'b1;
        avmm2_odat1 = 1'b1;
        tick();
        avmm2_odat0 = 1'b1;
        avmm2_odat1 = 1'b0;
        tick();
        avmm2_odat0 = 1'b0;
        avmm2_odat1 = 1'b1;
        avmm_sync_rstb = 1'b0;
        #1;
        check("midrst_pads", 32'({avmm2_idat1, avmm2_idat0}), 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        avmm2_odat0 = 1'b0;
        avmm2_odat1 = 1'b0;
        repeat (2) tick();
        avmm_sync_rstb = 1'b1;
        repeat (12) tick();
        check("midrst_no_rx_valid", 32'(rx_pulses - p0), 32'd0);
        fork
            send_tx(16'h8421, 16'h8241);
            rx_frame(8'h33, 8'h33, 16'h0F0F);
        join
        repeat (4) tick();

        // Enable dropped mid-TX: frame finishes, no new accept.
        send_tx(16'h8421, 16'h8241);
        repeat (2) tick();
        avmm2_en = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 16'h5A5A;
        cur_exp  = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("en_low_ready", 32'(tx_ready), 32'd0);
        end
        tx_valid = 1'b0;
        avmm2_en = 1'b1;
        repeat (3) tick();

        // Enable dropped mid-RX: frame completes; a header seen while disabled is ignored.
        p0 = rx_pulses;
        fork
            rx_frame(8'hFF, 8'h00, 16'h5555);
            begin
                repeat (3) tick();
                avmm2_en = 1'b0;
            end
        join
        avmm2_odat0 = 1'b1;
        avmm2_odat1 = 1'b1;
        tick();
        avmm2_odat0 = 1'b0;
        avmm2_odat1 = 1'b0;
        repeat (12) tick();
        check("en_low_rx_pulses", 32'(rx_pulses - p0), 32'd1);
        avmm2_en = 1'b1;

        repeat (10) tick();
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
